// File: rtl/exe_mem_stage_if.sv
// Signal bundle between the ID/EXE register, hazard/forwarding sources and the
// execute stage with its EX/MEM pipeline register.
interface exe_mem_stage_if;
  logic        stall;
  logic        flush;
  logic        mem_to_reg_in;
  logic        reg_write_in;
  logic        mem_write_in;
  logic        mem_read_in;
  logic        alu_src_in;
  logic        reg_dst_in;
  logic [2:0]  alu_op_in;
  logic [31:0] read_data1_in;
  logic [31:0] read_data2_in;
  logic [31:0] address_in;
  logic [4:0]  rs_in;
  logic [4:0]  rt_in;
  logic [4:0]  rd_in;
  logic        mem_reg_write;
  logic        wb_reg_write;
  logic [4:0]  mem_rd;
  logic [4:0]  wb_rd;
  logic [31:0] mem_fwd_data;
  logic [31:0] wb_fwd_data;
  logic        mem_to_reg_out;
  logic        reg_write_out;
  logic        mem_write_out;
  logic        mem_read_out;
  logic [31:0] alu_result_out;
  logic [31:0] store_data_out;
  logic [4:0]  dst_reg_out;
  logic        zero_out;

  modport master (
    output stall, flush, mem_to_reg_in, reg_write_in, mem_write_in, mem_read_in,
           alu_src_in, reg_dst_in, alu_op_in, read_data1_in, read_data2_in,
           address_in, rs_in, rt_in, rd_in, mem_reg_write, wb_reg_write,
           mem_rd, wb_rd, mem_fwd_data, wb_fwd_data,
    input  mem_to_reg_out, reg_write_out, mem_write_out, mem_read_out,
           alu_result_out, store_data_out, dst_reg_out, zero_out
  );

  modport slave (
    input  stall, flush, mem_to_reg_in, reg_write_in, mem_write_in, mem_read_in,
           alu_src_in, reg_dst_in, alu_op_in, read_data1_in, read_data2_in,
           address_in, rs_in, rt_in, rd_in, mem_reg_write, wb_reg_write,
           mem_rd, wb_rd, mem_fwd_data, wb_fwd_data,
    output mem_to_reg_out, reg_write_out, mem_write_out, mem_read_out,
           alu_result_out, store_data_out, dst_reg_out, zero_out
  );
endinterface

// File: rtl/exe_mem_stage.sv
// MIPS execute stage plus EX/MEM register. Define EXE_FORWARD_EN to build the
// MEM/WB forwarding muxes; without it operands come straight from ID/EXE.
module exe_mem_stage (
  input logic           clk,
  input logic           rst,
  exe_mem_stage_if.slave bus
);

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic [4:0]  dst_reg;

`ifdef EXE_FORWARD_EN
  // MEM is the younger producer, so it wins over WB; r0 is never forwarded.
  always_comb begin
    fwd_a = bus.read_data1_in;
    if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == bus.rs_in))
      fwd_a = bus.mem_fwd_data;
    else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.rs_in))
      fwd_a = bus.wb_fwd_data;
  end

  always_comb begin
    fwd_b = bus.read_data2_in;
    if (bus.mem_reg_write && (bus.mem_rd != 5'd0) && (bus.mem_rd == bus.rt_in))
      fwd_b = bus.mem_fwd_data;
    else if (bus.wb_reg_write && (bus.wb_rd != 5'd0) && (bus.wb_rd == bus.rt_in))
      fwd_b = bus.wb_fwd_data;
  end
`else
  logic unused_fwd_inputs;

  assign fwd_a = bus.read_data1_in;
  assign fwd_b = bus.read_data2_in;
  assign unused_fwd_inputs = ^{bus.mem_reg_write, bus.wb_reg_write, bus.mem_rd,
                               bus.wb_rd, bus.mem_fwd_data, bus.wb_fwd_data,
                               bus.rs_in};
`endif

  assign op_b    = bus.alu_src_in ? bus.address_in : fwd_b;
  assign dst_reg = bus.reg_dst_in ? bus.rd_in : bus.rt_in;

  always_comb begin
    alu_result = 32'h0;
    case (bus.alu_op_in)
      3'b000:  alu_result = fwd_a & op_b;
      3'b001:  alu_result = fwd_a | op_b;
      3'b010:  alu_result = fwd_a + op_b;
      3'b110:  alu_result = fwd_a - op_b;
      3'b111:  alu_result = ($signed(fwd_a) < $signed(op_b)) ? 32'h1 : 32'h0;
      3'b011:  alu_result = ~(fwd_a | op_b);
      default: alu_result = 32'h0;
    endcase
  end

  // Register control: flush loads an all-zero bubble and beats stall; stall
  // holds every output; otherwise the new execute results are captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_to_reg_out <= 1'b0;
      bus.reg_write_out  <= 1'b0;
      bus.mem_write_out  <= 1'b0;
      bus.mem_read_out   <= 1'b0;
      bus.alu_result_out <= 32'h0;
      bus.store_data_out <= 32'h0;
      bus.dst_reg_out    <= 5'd0;
      bus.zero_out       <= 1'b0;
    end else if (bus.flush) begin
      bus.mem_to_reg_out <= 1'b0;
      bus.reg_write_out  <= 1'b0;
      bus.mem_write_out  <= 1'b0;
      bus.mem_read_out   <= 1'b0;
      bus.alu_result_out <= 32'h0;
      bus.store_data_out <= 32'h0;
      bus.dst_reg_out    <= 5'd0;
      bus.zero_out       <= 1'b0;
    end else if (!bus.stall) begin
      bus.mem_to_reg_out <= bus.mem_to_reg_in;
      bus.reg_write_out  <= bus.reg_write_in;
      bus.mem_write_out  <= bus.mem_write_in;
      bus.mem_read_out   <= bus.mem_read_in;
      bus.alu_result_out <= alu_result;
      bus.store_data_out <= fwd_b;
      bus.dst_reg_out    <= dst_reg;
      bus.zero_out       <= (alu_result == 32'h0);
    end
  end

endmodule

// File: tb/tb_exe_mem_stage.sv
// Self-checking bench for exe_mem_stage; expected results follow EXE_FORWARD_EN.
module tb_exe_mem_stage;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [73:0] exp_q[$];

  exe_mem_stage_if bus ();

  exe_mem_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: {mem_to_reg, reg_write, mem_write, mem_read, alu, store, dst, zero}
  function automatic logic [73:0] out_vec();
    return {bus.mem_to_reg_out, bus.reg_write_out, bus.mem_write_out,
            bus.mem_read_out, bus.alu_result_out, bus.store_data_out,
            bus.dst_reg_out, bus.zero_out};
  endfunction

  function automatic logic [73:0] pack(logic [3:0] ctrl, logic [31:0] alu,
                                       logic [31:0] store, logic [4:0] dst);
    return {ctrl, alu, store, dst, (alu == 32'h0)};
  endfunction

  // Reference model built from the current stimulus on the interface.
  function automatic logic [73:0] model_expect();
    logic [31:0] a, b, opb, r;
    a = bus.read_data1_in;
    b = bus.read_data2_in;
`ifdef EXE_FORWARD_EN
    if (bus.mem_reg_write && bus.mem_rd != 0 && bus.mem_rd == bus.rs_in) a = bus.mem_fwd_data;
    else if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == bus.rs_in) a = bus.wb_fwd_data;
    if (bus.mem_reg_write && bus.mem_rd != 0 && bus.mem_rd == bus.rt_in) b = bus.mem_fwd_data;
    else if (bus.wb_reg_write && bus.wb_rd != 0 && bus.wb_rd == bus.rt_in) b = bus.wb_fwd_data;
`endif
    opb = bus.alu_src_in ? bus.address_in : b;
    case (bus.alu_op_in)
      3'b000: r = a & opb;
      3'b001: r = a | opb;
      3'b010: r = a + opb;
      3'b110: r = a - opb;
      3'b111: r = {31'h0, $signed(a) < $signed(opb)};
      3'b011: r = ~(a | opb);
      default: r = 32'h0;
    endcase
    return pack({bus.mem_to_reg_in, bus.reg_write_in, bus.mem_write_in, bus.mem_read_in},
                r, b, bus.reg_dst_in ? bus.rd_in : bus.rt_in);
  endfunction

  task automatic clear_inputs();
    bus.stall = 0; bus.flush = 0;
    bus.mem_to_reg_in = 0; bus.reg_write_in = 0; bus.mem_write_in = 0; bus.mem_read_in = 0;
    bus.alu_src_in = 0; bus.reg_dst_in = 0; bus.alu_op_in = 3'b000;
    bus.read_data1_in = 0; bus.read_data2_in = 0; bus.address_in = 0;
    bus.rs_in = 0; bus.rt_in = 0; bus.rd_in = 0;
    bus.mem_reg_write = 0; bus.wb_reg_write = 0; bus.mem_rd = 0; bus.wb_rd = 0;
    bus.mem_fwd_data = 0; bus.wb_fwd_data = 0;
  endtask

  task automatic test_reset();
    logic [73:0] got;
    logic [73:0] exp;
    checks++;
    if (out_vec() !== 74'h0) begin
      errors++; $display("FAIL reset_initial got %h exp %h", out_vec(), 74'h0);
    end
    @(negedge clk);
    rst = 0;
    bus.reg_write_in = 1; bus.mem_read_in = 1; bus.mem_to_reg_in = 1;
    bus.read_data1_in = 32'h40; bus.read_data2_in = 32'h77; bus.alu_src_in = 1;
    bus.address_in = 32'h4; bus.alu_op_in = 3'b010; bus.rt_in = 5'd3;
    exp_q.push_back(pack(4'b1101, 32'h44, 32'h77, 5'd3));
    @(posedge clk); #1;
    got = out_vec(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_preload got %h exp %h", got, exp); end
    @(negedge clk); #2;
    rst = 1;
    #1;
    checks++;
    if (out_vec() !== 74'h0) begin
      errors++; $display("FAIL reset_async got %h exp %h", out_vec(), 74'h0);
    end
    @(posedge clk); #1;
    checks++;
    if (out_vec() !== 74'h0) begin
      errors++; $display("FAIL reset_held got %h exp %h", out_vec(), 74'h0);
    end
    @(negedge clk);
    rst = 0;
    exp_q.push_back(pack(4'b1101, 32'h44, 32'h77, 5'd3));
    @(posedge clk); #1;
    got = out_vec(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_release got %h exp %h", got, exp); end
  endtask

  task automatic test_alu();
    logic [31:0] ta[11], tb[11], tr[11];
    logic [2:0]  top[11];
    logic [73:0] got;
    logic [73:0] exp;
    ta  = '{32'h7FFFFFFF, 32'h5, 32'hFFFFFFFF, 32'h1, 32'hF0F000FF, 32'hF0F000FF,
            32'hF0F000FF, 32'h0, 32'h12345678, 32'h12345678, 32'h80000000};
    tb  = '{32'h1, 32'h5, 32'h1, 32'hFFFFFFFF, 32'h0FF0F00F, 32'h0FF0F00F,
            32'h0FF0F00F, 32'h1, 32'h9, 32'h9, 32'h7FFFFFFF};
    top = '{3'b010, 3'b110, 3'b111, 3'b111, 3'b000, 3'b001,
            3'b011, 3'b110, 3'b100, 3'b101, 3'b111};
    tr  = '{32'h80000000, 32'h0, 32'h1, 32'h0, 32'h00F0000F, 32'hFFF0F0FF,
            32'h000F0F00, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h1};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      clear_inputs();
      bus.reg_write_in = 1; bus.reg_dst_in = 1; bus.rd_in = 5'(i + 1);
      bus.alu_src_in = 1; bus.read_data1_in = ta[i]; bus.address_in = tb[i];
      bus.alu_op_in = top[i]; bus.read_data2_in = 32'h1234;
      exp_q.push_back(pack(4'b0100, tr[i], 32'h1234, 5'(i + 1)));
      @(posedge clk); #1;
      got = out_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL alu_%0d got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] tr[4];
    logic [31:0] ts[4];
    logic [73:0] got;
    logic [73:0] exp;
`ifdef EXE_FORWARD_EN
    tr = '{32'd11, 32'd21, 32'd31, 32'd40};
    ts = '{32'h55, 32'h55, 32'h55, 32'd10};
`else
    tr = '{32'd31, 32'd31, 32'd31, 32'h73};
    ts = '{32'h55, 32'h55, 32'h55, 32'h55};
`endif
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_inputs();
      bus.reg_write_in = 1; bus.alu_op_in = 3'b010; bus.rd_in = 5'd12; bus.reg_dst_in = 1;
      bus.read_data1_in = 32'd30; bus.read_data2_in = 32'h55;
      bus.rs_in = 5'd3; bus.rt_in = 5'd7; bus.alu_src_in = 1; bus.address_in = 32'd1;
      bus.mem_reg_write = 1; bus.mem_rd = 5'd3; bus.mem_fwd_data = 32'd10;
      bus.wb_reg_write = 1;  bus.wb_rd = 5'd3;  bus.wb_fwd_data = 32'd20;
      if (i == 1) bus.mem_rd = 5'd0;
      if (i == 2) begin bus.mem_reg_write = 0; bus.wb_reg_write = 0; end
      if (i == 3) begin bus.rs_in = 5'd1; bus.rt_in = 5'd3; bus.alu_src_in = 0; end
      exp_q.push_back(pack(4'b0100, tr[i], ts[i], 5'd12));
      @(posedge clk); #1;
      got = out_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL fwd_%0d got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_store();
    logic [73:0] got;
    logic [73:0] exp;
    logic [31:0] sd;
`ifdef EXE_FORWARD_EN
    sd = 32'hDEAD;
`else
    sd = 32'h1111;
`endif
    @(negedge clk);
    clear_inputs();
    bus.mem_write_in = 1; bus.alu_src_in = 1; bus.address_in = 32'd8; bus.alu_op_in = 3'b010;
    bus.rs_in = 5'd2; bus.rt_in = 5'd4; bus.rd_in = 5'd17;
    bus.read_data1_in = 32'h100; bus.read_data2_in = 32'h1111;
    bus.wb_reg_write = 1; bus.wb_rd = 5'd4; bus.wb_fwd_data = 32'hDEAD;
    exp_q.push_back(pack(4'b0010, 32'h108, sd, 5'd4));
    @(posedge clk); #1;
    got = out_vec(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL store got %h exp %h", got, exp); end
  endtask

  task automatic test_reg_dst();
    logic [73:0] got;
    logic [73:0] exp;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      clear_inputs();
      bus.reg_write_in = 1; bus.rt_in = 5'd5; bus.rd_in = 5'd9; bus.reg_dst_in = i[0];
      bus.read_data1_in = 32'h3; bus.read_data2_in = 32'h4; bus.alu_op_in = 3'b001;
      exp_q.push_back(pack(4'b0100, 32'h7, 32'h4, (i == 0) ? 5'd5 : 5'd9));
      @(posedge clk); #1;
      got = out_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL reg_dst_%0d got %h exp %h", i, got, exp); end
    end
  endtask

  task automatic test_stall_flush();
    logic [73:0] got;
    logic [73:0] exp;
    logic [73:0] lw_exp;
    @(negedge clk);
    clear_inputs();
    bus.mem_read_in = 1; bus.mem_to_reg_in = 1; bus.reg_write_in = 1; bus.alu_src_in = 1;
    bus.address_in = 32'h4; bus.read_data1_in = 32'h200; bus.read_data2_in = 32'h9;
    bus.alu_op_in = 3'b010; bus.rt_in = 5'd6;
    lw_exp = pack(4'b1101, 32'h204, 32'h9, 5'd6);
    exp_q.push_back(lw_exp);
    @(posedge clk); #1;
    got = out_vec(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL lw_load got %h exp %h", got, exp); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.stall = 1;
      bus.read_data1_in = $urandom; bus.read_data2_in = $urandom; bus.rt_in = 5'($urandom_range(1, 31));
      bus.mem_write_in = 1; bus.mem_read_in = 0; bus.alu_op_in = 3'($urandom_range(0, 7));
      exp_q.push_back(lw_exp);
      @(posedge clk); #1;
      got = out_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL stall_%0d got %h exp %h", i, got, exp); end
    end
    @(negedge clk);
    bus.stall = 1; bus.flush = 1;
    exp_q.push_back(74'h0);
    @(posedge clk); #1;
    got = out_vec(); exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL flush_over_stall got %h exp %h", got, exp); end
    @(negedge clk);
    bus.stall = 0; bus.flush = 0;
  endtask

  task automatic test_back_to_back();
    logic [73:0] got;
    logic [73:0] exp;
    logic [73:0] held;
    held = 74'h0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      {bus.mem_to_reg_in, bus.reg_write_in, bus.mem_write_in, bus.mem_read_in} = 4'($urandom);
      bus.alu_src_in = $urandom_range(0, 1); bus.reg_dst_in = $urandom_range(0, 1);
      bus.alu_op_in = 3'($urandom_range(0, 7));
      bus.read_data1_in = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      bus.read_data2_in = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      bus.address_in = $urandom;
      bus.rs_in = 5'($urandom_range(0, 3)); bus.rt_in = 5'($urandom_range(0, 3));
      bus.rd_in = 5'($urandom);
      bus.mem_reg_write = $urandom_range(0, 1); bus.wb_reg_write = $urandom_range(0, 1);
      bus.mem_rd = 5'($urandom_range(0, 3)); bus.wb_rd = 5'($urandom_range(0, 3));
      bus.mem_fwd_data = $urandom; bus.wb_fwd_data = $urandom;
      if (bus.flush) held = 74'h0;
      else if (!bus.stall) held = model_expect();
      exp_q.push_back(held);
      @(posedge clk); #1;
      got = out_vec(); exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_%0d got %h exp %h", i, got, exp); end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1;
    clear_inputs();
    #3;
    test_reset();
    test_alu();
    test_forwarding();
    test_store();
    test_reg_dst();
    test_stall_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
